// File: rtl/fetch_stage_pkg.sv
// Shared pipeline constants and the IF/ID record for the fetch stage.
// No logic or latency; the stall rule that holds IF/ID lives in if_id_reg.
package fetch_stage_pkg;

  localparam int          XLEN         = 32;
  localparam int          INSTR_W      = 32;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc4;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } if_id_t;

  function automatic if_id_t if_id_bubble(input logic [INSTR_W-1:0] nop);
    if_id_t b;
    b.pc    = '0;
    b.pc4   = '0;
    b.instr = nop;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port plus the IF/ID outputs of the fetch stage.
// Pure wiring; the master side is the fetch stage, the slave side is memory/decode.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic [XLEN-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [XLEN-1:0]    IF_ID_pc;
  logic [XLEN-1:0]    IF_ID_pc4;
  logic [INSTR_W-1:0] IF_ID_instr;
  logic               IF_ID_valid;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output IF_ID_pc,
    output IF_ID_pc4,
    output IF_ID_instr,
    output IF_ID_valid
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  IF_ID_pc,
    input  IF_ID_pc4,
    input  IF_ID_instr,
    input  IF_ID_valid
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: one-cycle capture, flush beats stall, stall holds all fields.
// Reset and flush both load a bubble (NOP, pc/pc4 zero, valid low).
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  input  logic   stall,
  input  if_id_t cap_dat,
  output if_id_t if_id_dat
);

  if_id_t if_id_d;
  if_id_t if_id_q;

  always_comb begin
    if_id_d = if_id_q;
    if (flush) begin
      if_id_d = if_id_bubble(NOP_INSTR);
    end else if (!stall) begin
      if_id_d = cap_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_q <= if_id_bubble(NOP_INSTR);
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign if_id_dat = if_id_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, next-PC mux, flush counter and misaligned flag; IF/ID one cycle behind.
// A redirect always wins over stall so a taken branch is never dropped while frozen.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 PCSrc,
  input  logic [31:0]          branch_target,
  input  logic                 IF_ID_Flush,
  input  logic                 stall,
  fetch_stage_if.master        bus,
  output logic [15:0]          flush_count,
  output logic                 misaligned
);

  logic [31:0] pc_d, pc_q;
  logic [31:0] pc_plus4;
  logic [15:0] flush_count_d, flush_count_q;
  logic        misaligned_d, misaligned_q;
  if_id_t      cap_dat;
  if_id_t      if_id_dat;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_plus4;
    if (PCSrc) begin
      pc_d = {branch_target[31:2], 2'b00};
    end else if (stall) begin
      pc_d = pc_q;
    end

    flush_count_d = flush_count_q;
    if (IF_ID_Flush && (flush_count_q != 16'hFFFF)) begin
      flush_count_d = flush_count_q + 16'd1;
    end

    // Sticky until reset: software inspects it after the fact.
    misaligned_d = misaligned_q | (PCSrc & (branch_target[1:0] != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      flush_count_q <= 16'd0;
      misaligned_q  <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      flush_count_q <= flush_count_d;
      misaligned_q  <= misaligned_d;
    end
  end

  always_comb begin
    cap_dat.pc    = pc_q;
    cap_dat.pc4   = pc_plus4;
    cap_dat.instr = bus.imem_rdata;
    cap_dat.valid = 1'b1;
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
    .clk       (clk),
    .reset     (reset),
    .flush     (IF_ID_Flush),
    .stall     (stall),
    .cap_dat   (cap_dat),
    .if_id_dat (if_id_dat)
  );

  assign bus.imem_addr   = pc_q;
  assign bus.IF_ID_pc    = if_id_dat.pc;
  assign bus.IF_ID_pc4   = if_id_dat.pc4;
  assign bus.IF_ID_instr = if_id_dat.instr;
  assign bus.IF_ID_valid = if_id_dat.valid;
  assign flush_count     = flush_count_q;
  assign misaligned      = misaligned_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), is the bubble instruction.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 PCSrc  input  1  redirect request: load branch_target into PC.
REQ-006 branch_target  input  32  redirect address for PCSrc.
REQ-007 IF_ID_Flush  input  1  squash the IF/ID register contents.
REQ-008 stall  input  1  hazard-unit freeze of PC and IF/ID.
REQ-009 imem_addr  output  32  instruction memory address, equal to current PC.
REQ-010 imem_rdata  input  32  instruction at imem_addr, combinational read, same cycle.
REQ-011 IF_ID_pc  output  32  PC of the instruction held in IF/ID.
REQ-012 IF_ID_pc4  output  32  IF_ID_pc + 4.
REQ-013 IF_ID_instr  output  32  instruction held in IF/ID.
REQ-014 IF_ID_valid  output  1  IF/ID holds a real (non-bubble) instruction.
REQ-015 flush_count  output  16  number of cycles with IF_ID_Flush asserted, saturating.
REQ-016 misaligned  output  1  sticky flag: a redirect target had bits[1:0] != 0.

Function
REQ-017 imem_addr SHALL equal the PC register combinationally.
REQ-018 PC next-state priority SHALL be: reset, then PCSrc, then stall, then default.
REQ-019 Each priority level SHALL load: reset -> RESET_PC; PCSrc -> {branch_target[31:2],2'b00}; stall -> PC unchanged; default -> PC+4.
REQ-020 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-021 IF/ID next-state priority SHALL be: reset, then IF_ID_Flush, then stall, then capture.
REQ-022 Reset and IF_ID_Flush SHALL both load IF/ID with instr=NOP_INSTR, pc=0, pc4=0, valid=0.
REQ-023 stall SHALL hold all IF/ID fields unchanged.
REQ-024 Capture SHALL load pc=PC, pc4=PC+4, instr=imem_rdata, valid=1.
REQ-025 Fetch latency SHALL be one cycle: the instruction addressed in cycle N appears on the IF_ID_* outputs in cycle N+1.
REQ-026 Simultaneous PCSrc and stall SHALL redirect the PC (the redirect is never lost).
REQ-027 Simultaneous IF_ID_Flush and stall SHALL flush IF/ID.
REQ-028 PCSrc without IF_ID_Flush SHALL redirect the PC while IF/ID captures normally.
REQ-029 IF_ID_Flush without PCSrc SHALL squash IF/ID while the PC advances per REQ-019.
REQ-030 flush_count SHALL increment by 1 on each edge where IF_ID_Flush=1 and reset=0.
REQ-031 flush_count SHALL saturate at 16'hFFFF.
REQ-032 misaligned SHALL set on an edge where PCSrc=1 and branch_target[1:0]!=0, and remain set until reset.

Reset
REQ-033 On a reset edge, outputs SHALL become: PC=RESET_PC, IF_ID_valid=0, IF_ID_instr=NOP_INSTR, IF_ID_pc=0, IF_ID_pc4=0, flush_count=0, misaligned=0.
REQ-034 Reset SHALL override all other inputs, including mid-stall and mid-redirect.
REQ-035 The first edge after reset deasserts SHALL capture RESET_PC with valid=1.

Structure
REQ-036 NOP_INSTR, RESET_PC default and the instruction width constant SHALL live in the shared pipeline defines header.
REQ-037 The IF/ID register (flush/stall/capture, REQ-021 to REQ-024) SHALL be a sub-module if_id_reg.
REQ-038 The PC register, next-PC mux and counters SHALL live in fetch_stage.
REQ-039 Target size SHALL be 120-400 lines of RTL in total.

Verification
REQ-040 Reset then 3 free cycles with imem_rdata=A,B,C -> IF_ID_pc sequence 0,4,8 with valid=1; instr=A,B,C.
REQ-041 stall=1 for 2 cycles at PC=8 -> PC stays 8 and IF/ID holds; on release, PC=12.
REQ-042 PCSrc=1, IF_ID_Flush=1, target=0x100 -> next cycle PC=0x100, valid=0, instr=0x13, flush_count=1.
REQ-043 PCSrc=1 with stall=1 and target=0x202 -> PC=0x200, misaligned=1 and remains 1 until reset.
REQ-044 PC forced to 0xFFFFFFFC, free run -> PC=0x0 and IF_ID_pc4=0x0.
REQ-045 flush_count preset near saturation via 65536+ flush cycles -> holds 0xFFFF; reset asserted during a redirect -> all outputs per REQ-033.
